// File: rtl/display_scan_controller.sv
// Time-multiplexed scan for common-anode seven-segment digits sharing one hex decoder.
// Values arrive over valid/ready and are committed to the displayed shadow only at frame wrap.
module display_scan_controller #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [4*DIGITS-1:0] in_value,
    output logic                in_ready,
    input  logic                enable,
    input  logic                lzs,
    output logic [3:0]          digit_code,
    output logic [DIGITS-1:0]   anode_n,
    output logic                frame_tick
);

    localparam int VW     = 4 * DIGITS;
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W  = $clog2(REFRESH_DIV);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]  GUARD_CNT = DIV_W'(GUARD);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot;
    logic [VW-1:0]     pending;
    logic [VW-1:0]     shadow;
    logic              pend_full;
    logic              frame_armed;

    logic [DIGITS-1:0] suppressed;
    logic [DIGITS-1:0] slot_onehot;
    logic [3:0]        slot_nibble;
    logic              slot_suppressed;
    logic              zero_above;
    logic              slot_end;
    logic              frame_wrap;
    logic              lit;
    logic              xfer;

    // A digit is suppressed when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        suppressed = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (shadow[4*i +: 4] == 4'h0);
            suppressed[i] = lzs && zero_above;
        end
        slot_onehot     = '0;
        slot_nibble     = 4'h0;
        slot_suppressed = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot == SLOT_W'(i)) begin
                slot_onehot[i]  = 1'b1;
                slot_nibble     = shadow[4*i +: 4];
                slot_suppressed = suppressed[i];
            end
        end
    end

    assign slot_end   = enable && (div_cnt == DIV_LAST);
    assign frame_wrap = slot_end && (slot == SLOT_LAST);
    assign lit        = enable && (div_cnt >= GUARD_CNT) && !slot_suppressed;
    assign xfer       = in_valid && !pend_full;
    assign in_ready   = ~pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            slot        <= '0;
            pending     <= '0;
            shadow      <= '0;
            pend_full   <= 1'b0;
            frame_armed <= 1'b0;
            anode_n     <= '1;
            digit_code  <= 4'h0;
            frame_tick  <= 1'b0;
        end else begin
            if (enable) begin
                if (slot_end) begin
                    div_cnt <= '0;
                    slot    <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            // A transfer can only happen with pending empty, so it never collides with a commit.
            if (xfer) begin
                pending   <= in_value;
                pend_full <= 1'b1;
            end else if (frame_wrap && pend_full) begin
                shadow    <= pending;
                pend_full <= 1'b0;
            end

            if (lit) begin
                anode_n    <= ~slot_onehot;
                digit_code <= slot_nibble;
            end else begin
                anode_n    <= '1;
                digit_code <= 4'h0;
            end

            // The tick lines up with the outputs of the first slot-0 cycle after a wrap.
            frame_tick <= enable && frame_armed && (div_cnt == '0) && (slot == '0);
            if (frame_wrap) begin
                frame_armed <= 1'b1;
            end else if (enable && (div_cnt == '0) && (slot == '0)) begin
                frame_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIGITS=4, REFRESH_DIV=4, GUARD=1 (16-cycle frame).
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_value = 16'h0;
    logic        in_ready;
    logic        enable = 1'b1;
    logic        lzs = 1'b0;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int c;

    logic [3:0] an_tab [4];

    display_scan_controller #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .in_ready   (in_ready),
        .enable     (enable),
        .lzs        (lzs),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        enable   = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        c   = -1;
    endtask

    task automatic test_reset();
        lzs = 1'b0;
        do_reset();
        n_cmp++;
        if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL reset_anode got %b want 1111", anode_n); end
        n_cmp++;
        if (digit_code !== 4'h0) begin n_bad++; $display("FAIL reset_code got %h want 0", digit_code); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_cmp++;
        if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        step();
        n_cmp++;
        if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL reset_guard got %b want 1111", anode_n); end
        step();
        n_cmp++;
        if (anode_n !== 4'b1110 || digit_code !== 4'h0)
            begin n_bad++; $display("FAIL reset_first_lit got %b/%h want 1110/0", anode_n, digit_code); end
    endtask

    task automatic test_load();
        logic [3:0] cd_tab [4];
        logic [3:0] ea;
        logic [3:0] ec;
        cd_tab = '{4'hF, 4'h3, 4'hA, 4'h1};
        lzs = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_value = 16'h1A3F;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_fall got %b want 0", in_ready); end
        while (c < 14) step();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_held got %b want 0", in_ready); end
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_rise got %b want 1", in_ready); end
        for (int i = 0; i < 16; i++) begin
            step();
            ea = (i % 4 == 0) ? 4'b1111 : an_tab[i/4];
            ec = (i % 4 == 0) ? 4'h0 : cd_tab[i/4];
            n_cmp++;
            if (anode_n !== ea || digit_code !== ec || frame_tick !== (i == 0))
                begin n_bad++; $display("FAIL load_frame i=%0d got %b/%h/%b want %b/%h/%b",
                                        i, anode_n, digit_code, frame_tick, ea, ec, (i == 0)); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ea;
        logic [3:0] ec;
        lzs = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_value = 16'h1111;
        step();
        in_value = 16'h2222;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low c=%0d got %b want 0", c, in_ready); end
            step();
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 0) begin
                in_valid = 1'b0;
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_xfer got %b want 0", in_ready); end
            end
            ea = (i % 4 == 0) ? 4'b1111 : an_tab[(i/4) % 4];
            ec = (i % 4 == 0) ? 4'h0 : ((i < 16) ? 4'h1 : 4'h2);
            n_cmp++;
            if (anode_n !== ea || digit_code !== ec)
                begin n_bad++; $display("FAIL bp_frame i=%0d got %b/%h want %b/%h", i, anode_n, digit_code, ea, ec); end
        end
    endtask

    task automatic test_lzs();
        logic [3:0] ea;
        logic [3:0] ec;
        lzs = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_value = 16'h0005;
        step();
        in_valid = 1'b0;
        while (c < 15) step();
        for (int i = 0; i < 16; i++) begin
            step();
            ea = (i >= 1 && i <= 3) ? 4'b1110 : 4'b1111;
            ec = (i >= 1 && i <= 3) ? 4'h5 : 4'h0;
            n_cmp++;
            if (anode_n !== ea || digit_code !== ec)
                begin n_bad++; $display("FAIL lzs_five i=%0d got %b/%h want %b/%h", i, anode_n, digit_code, ea, ec); end
        end
        in_valid = 1'b1;
        in_value = 16'h0000;
        step();
        in_valid = 1'b0;
        while (c < 47) step();
        for (int i = 0; i < 16; i++) begin
            step();
            ea = (i >= 1 && i <= 3) ? 4'b1110 : 4'b1111;
            n_cmp++;
            if (anode_n !== ea || digit_code !== 4'h0)
                begin n_bad++; $display("FAIL lzs_zero i=%0d got %b/%h want %b/0", i, anode_n, digit_code, ea); end
        end
        lzs = 1'b0;
    endtask

    task automatic test_enable();
        lzs = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_value = 16'h1A3F;
        step();
        in_valid = 1'b0;
        while (c < 25) step();
        n_cmp++;
        if (anode_n !== 4'b1011 || digit_code !== 4'hA)
            begin n_bad++; $display("FAIL en_before got %b/%h want 1011/a", anode_n, digit_code); end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (anode_n !== 4'b1111 || digit_code !== 4'h0 || frame_tick !== 1'b0)
                begin n_bad++; $display("FAIL en_blank i=%0d got %b/%h/%b want 1111/0/0", i, anode_n, digit_code, frame_tick); end
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (anode_n !== 4'b1011 || digit_code !== 4'hA)
                begin n_bad++; $display("FAIL en_resume i=%0d got %b/%h want 1011/a", i, anode_n, digit_code); end
        end
        step();
        n_cmp++;
        if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL en_slot3_guard got %b want 1111", anode_n); end
        step();
        n_cmp++;
        if (anode_n !== 4'b0111 || digit_code !== 4'h1)
            begin n_bad++; $display("FAIL en_slot3 got %b/%h want 0111/1", anode_n, digit_code); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea;
        lzs = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_value = 16'h1A3F;
        step();
        in_valid = 1'b0;
        while (c < 15) step();
        in_valid = 1'b1;
        in_value = 16'h5555;
        step();
        in_valid = 1'b0;
        while (c < 20) step();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_pending got %b want 0", in_ready); end
        rst = 1'b1;
        step();
        n_cmp++;
        if (anode_n !== 4'b1111 || digit_code !== 4'h0 || in_ready !== 1'b1 || frame_tick !== 1'b0)
            begin n_bad++; $display("FAIL rm_values got %b/%h/%b/%b want 1111/0/1/0",
                                    anode_n, digit_code, in_ready, frame_tick); end
        rst = 1'b0;
        c   = -1;
        for (int i = 0; i < 32; i++) begin
            step();
            ea = (i % 4 == 0) ? 4'b1111 : an_tab[(i/4) % 4];
            n_cmp++;
            if (anode_n !== ea || digit_code !== 4'h0)
                begin n_bad++; $display("FAIL rm_frame i=%0d got %b/%h want %b/0", i, anode_n, digit_code, ea); end
        end
    endtask

    initial begin
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        test_reset();
        test_load();
        test_backpressure();
        test_lzs();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing a single hex-to-segment decoder. It accepts 16-bit display values over a valid/ready handshake and double-buffers them so a new value is only committed at a frame boundary (no tearing). Each cycle it presents one nibble to the shared decoder and enables the matching digit anode, with guard blanking between slots and optional leading-zero suppression. It sits between the slave-side register logic and the board's display pins.

## Interface
- DIGITS, 4: number of digits scanned; value width is 4*DIGITS.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off; 1 ≤ GUARD < REFRESH_DIV.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a value on in_value.
- in_value  in  4*DIGITS  value to display; nibble i drives digit i, where digit 0 is rightmost.
- in_ready  out  1  pending buffer is empty; a transfer occurs when in_valid and in_ready are both high.
- enable  in  1  1 = scan and display; 0 = blank the display and freeze the scan.
- lzs  in  1  leading-zero suppression enable.
- digit_code  out  4  nibble to the shared decoder; bit3 drives A (MSB), bit0 drives D.
- anode_n  out  DIGITS  active-low digit enables; at most one bit is low.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

## Operation
- State:
  - div_cnt, 0..REFRESH_DIV-1.
  - slot, 0..DIGITS-1.
  - pending register plus pend_full flag.
  - shadow register holding the displayed value.
- Scan:
  - When enable=1, div_cnt increments each cycle.
  - At div_cnt=REFRESH_DIV-1: div_cnt→0 and slot→slot+1, wrapping DIGITS-1→0.
  - The wrap from slot DIGITS-1 to slot 0 is the frame boundary.
- Handshake:
  - in_ready = ~pend_full.
  - On a transfer, in_value is latched into pending and pend_full is set.
  - At a frame boundary with pend_full=1: pending is copied to shadow and pend_full is cleared.
  - A transfer in the same cycle as a boundary fills pending. That value is committed at the next boundary, not the current one.
  - While pend_full=1, in_valid is ignored. The producer holds its value.
- Display:
  - Lit condition: enable=1, div_cnt ≥ GUARD, and the slot is not suppressed.
  - When lit, anode_n has bit slot low and all others high, and digit_code = shadow nibble[slot].
  - Otherwise anode_n is all ones and digit_code = 0.
- Leading-zero suppression:
  - When lzs=1, slot i > 0 is suppressed if shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed, so a value of 0 displays as "0".
- enable=0:
  - div_cnt and slot hold their values; the display is blank.
  - The handshake still operates, but no commit occurs because no boundary is reached.
  - On re-enable, the scan resumes at the held slot and count.
- frame_tick: high for one cycle, coincident with the registered outputs of the first cycle of slot 0.

## Timing
- anode_n, digit_code and frame_tick are registered. Each reflects the div_cnt/slot/shadow state of the previous cycle, i.e. 1-cycle latency.
- Reset values: anode_n all ones, digit_code 0, frame_tick 0, in_ready 1, div_cnt 0, slot 0, shadow 0, pend_full 0.
- in_ready is registered. It falls the cycle after a transfer and rises the cycle after the commit.
- Commit latency: from transfer to the first lit cycle showing the new value is at most 2 frames plus GUARD+1 cycles.
- Frame length is DIGITS*REFRESH_DIV cycles while enabled. Per slot: GUARD blank cycles, then REFRESH_DIV-GUARD lit cycles.
- rst mid-frame:
  - All state returns to reset values on the next edge.
  - The pending value is discarded; in_ready=1 after reset.

## Test plan
Benches use DIGITS=4, REFRESH_DIV=4, GUARD=1.

- Reset: hold rst 3 cycles → anode_n=1111, digit_code=0, in_ready=1, frame_tick=0; after release, first lit cycle (anode_n=1110) appears 2 cycles later.
- Load 16'h1A3F, lzs=0 → after the commit boundary, the next frame shows each slot for 3 lit cycles after 1 blank cycle:
  - slot 0: F with 1110
  - slot 1: 3 with 1101
  - slot 2: A with 1011
  - slot 3: 1 with 0111
- Backpressure: offer 16'h1111 then 16'h2222 back-to-back with in_valid held →
  - the first transfers immediately;
  - in_ready stays 0 until the boundary;
  - the second transfers the cycle after in_ready rises;
  - the display shows 1111 for one full frame before 2222.
- LZS: lzs=1, value 16'h0005 → only slot 0 lit, showing 5; anode_n=1111 throughout slots 1–3. With value 0 → slot 0 shows 0.
- enable=0 mid slot 2 → anode_n=1111 the next cycle and counters frozen; re-enable → remaining lit cycles of slot 2 complete, then slot 3.
- Reset mid-frame with pend_full=1 → reset values restored, shadow=0; the pending value never appears on the display.
